axil_pwm_slave: RTL
===================

# axil_pwm_slave

Write-only AXI-Lite slave with a four-register PWM generator, directly downstream of the AXI4-to-AXI-Lite write adapter. It consumes the adapter's 4-bit word address, 32-bit data and AW/W/B handshakes, and drives one PWM output. PERIOD and DUTY are double-buffered so that updates take effect only at a period boundary.

## Interface
- CNT_W, 16, width of the PWM counter, PERIOD and DUTY (1..32).
- PRE_W, 16, width of the prescaler counter and the PRESCALE register (1..32).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high; clock clk.
- axil_awaddr  in  4  byte address; bits [3:2] select the register, bits [1:0] are ignored.
- axil_awvalid  in  1  write address valid.
- axil_awready  out  1  write address ready.
- axil_wdata  in  32  write data. No strobes; every write is full-word.
- axil_wvalid  in  1  write data valid.
- axil_wready  out  1  write data ready.
- axil_bvalid  out  1  write response valid. No bresp; every write is OKAY.
- axil_bready  in  1  write response ready.
- pwm_out  out  1  PWM output (registered).
- period_tick  out  1  one-cycle pulse at each enabled period wrap.

## Operation
- Register map:
  - 0x0 CTRL: bit0 EN, bit1 POL; other bits are ignored.
  - 0x4 PERIOD: pending PERIOD, [CNT_W-1:0].
  - 0x8 DUTY: pending DUTY, [CNT_W-1:0].
  - 0xC PRESCALE: [PRE_W-1:0], takes effect immediately.
- Upper data bits beyond a register's width are discarded.
- Write channel uses flags aw_held and w_held:
  - axil_awready = !aw_held && !axil_bvalid.
  - axil_wready = !w_held && !axil_bvalid.
  - An AW handshake latches the address and sets aw_held. A W handshake latches the data and sets w_held.
  - AW and W may arrive in either order or in the same cycle.
- Commit: on the edge where both address and data are available (held, or handshaking this cycle):
  - the register is written;
  - axil_bvalid is set and both flags are cleared.
- axil_bvalid stays high until axil_bready is sampled high. It clears on that edge; AW/W ready reassert the following cycle.
- Only one write is outstanding at a time.
- Prescaler: pre_cnt counts 0..PRESCALE and emits a tick at its wrap. PRESCALE=0 produces a tick every cycle.
- Counter: on each tick, cnt advances 0..period_act. At wrap (cnt==period_act and tick), cnt returns to 0 and period_tick pulses.
- Shadow load:
  - period_act/duty_act load from the pending registers at each wrap.
  - They also load continuously while EN=0.
- Output: pwm_out = ((cnt < duty_act) ^ POL) when EN=1; pwm_out = POL when EN=0.
- Boundaries:
  - DUTY=0: output constantly inactive.
  - DUTY>PERIOD: output constantly active.
  - PERIOD=0: every tick is a wrap.
- EN=0 holds pre_cnt and cnt at 0 and period_tick at 0.

## Timing
- Reset values:
  - axil_awready=1, axil_wready=1, axil_bvalid=0.
  - pwm_out=0, period_tick=0.
  - All registers, shadows and counters are 0.
- Reset mid-transaction drops any held AW/W and bvalid; the write is lost.
- Minimum write latency: AW and W in the same cycle (edge N) → bvalid high from N+1. With bready already high, the handshake completes at N+1 and readys return at N+2.
- Adapter order (AW first, then W): bvalid rises on the edge of the W handshake.
- CTRL write is visible in pwm_out 1 cycle after the commit edge. PERIOD/DUTY writes take effect from the next wrap.
- A write to PERIOD/DUTY that commits on a wrap edge is loaded at the next wrap, not the current one.
- period_tick and pwm_out are registered and change on the same edge as cnt.

## Structure
- A shared package holds:
  - register offsets (CTRL=0x0, PERIOD=0x4, DUTY=0x8, PRESCALE=0xC);
  - CTRL bit indices (EN=0, POL=1).
- One natural sub-module: pwm_core (prescaler, counter, shadows, output). The top level keeps the AXI-Lite write FSM and the register file.

## Test plan
- Reset, then idle: awready=wready=1, bvalid=0, pwm_out=0.
- AW 0x4 in cycle 0, W 0x9 in cycle 2, bready held at 1 → bvalid in cycle 3 only, one cycle long. AW and W in the same cycle also produce exactly one bvalid.
- PERIOD=9, DUTY=3, PRESCALE=0, CTRL=1 → pwm_out high for 3 cycles and low for 7, repeating; period_tick every 10 cycles.
- While running, write DUTY=5 mid-period → current period keeps 3 high cycles, next period has 5.
- Write CTRL=3 (POL=1) with DUTY=0 → pwm_out constantly 1. Then CTRL=2 → pwm_out=1, counters frozen at 0, no period_tick.
- PRESCALE=1, PERIOD=1, DUTY=1 → 4-cycle period, 2 high. Assert rst mid-write with bvalid pending → bvalid=0 and registers cleared next cycle.

Source files
------------

// File: rtl/axil_pwm_slave_pkg.sv
// Shared constants for the AXI-Lite PWM slave.
// Contents: register byte offsets and CTRL bit positions.
package axil_pwm_slave_pkg;

  // Register byte offsets (word aligned, bits [1:0] are don't-care on the bus)
  localparam logic [3:0] AddrCtrl     = 4'h0;
  localparam logic [3:0] AddrPeriod   = 4'h4;
  localparam logic [3:0] AddrDuty     = 4'h8;
  localparam logic [3:0] AddrPrescale = 4'hC;

  // CTRL register bit positions
  localparam int unsigned CtrlEnIdx  = 0;
  localparam int unsigned CtrlPolIdx = 1;

endpackage

// File: rtl/axil_pwm_slave_pwm_core.sv
// PWM engine: prescaler, period counter, double-buffered PERIOD/DUTY shadows and
// registered output.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_en, i_pol       enable and output polarity
//   i_period, i_duty  pending PERIOD/DUTY (loaded at wrap, or continuously while disabled)
//   i_prescale        prescaler terminal count, used directly
//   o_pwm             registered PWM output
//   o_period_tick     one-cycle pulse after each enabled period wrap
module axil_pwm_slave_pwm_core #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_pol,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  input  logic [PRE_W-1:0] i_prescale,
  output logic             o_pwm,
  output logic             o_period_tick
);

  logic [PRE_W-1:0] r_pre_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_act;
  logic [CNT_W-1:0] r_duty_act;
  logic             r_pwm;
  logic             r_tick;

  logic             w_pre_tick;
  logic             w_wrap;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic [CNT_W-1:0] w_duty_nxt;

  always_comb begin
    // >= so that lowering PRESCALE below the running count still wraps promptly
    w_pre_tick   = (r_pre_cnt >= i_prescale);
    w_wrap       = w_pre_tick && (r_cnt == r_period_act);
    w_pre_nxt    = w_pre_tick ? '0 : r_pre_cnt + 1'b1;
    w_cnt_nxt    = r_cnt;
    if (w_pre_tick) begin
      w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
    end
    w_period_nxt = w_wrap ? i_period : r_period_act;
    w_duty_nxt   = w_wrap ? i_duty : r_duty_act;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt    <= '0;
      r_cnt        <= '0;
      r_period_act <= '0;
      r_duty_act   <= '0;
      r_pwm        <= 1'b0;
      r_tick       <= 1'b0;
    end else if (!i_en) begin
      r_pre_cnt    <= '0;
      r_cnt        <= '0;
      r_period_act <= i_period;
      r_duty_act   <= i_duty;
      r_pwm        <= i_pol;
      r_tick       <= 1'b0;
    end else begin
      r_pre_cnt    <= w_pre_nxt;
      r_cnt        <= w_cnt_nxt;
      r_period_act <= w_period_nxt;
      r_duty_act   <= w_duty_nxt;
      // Output is computed from next-state values so it changes on the same edge as cnt
      r_pwm        <= (w_cnt_nxt < w_duty_nxt) ^ i_pol;
      r_tick       <= w_wrap;
    end
  end

  assign o_pwm         = r_pwm;
  assign o_period_tick = r_tick;

endmodule

// File: rtl/axil_pwm_slave.sv
// Write-only AXI-Lite slave with four PWM control registers.
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   axil_awaddr/awvalid/awready            write address channel (4-bit byte address)
//   axil_wdata/wvalid/wready               write data channel (full-word writes)
//   axil_bvalid/bready                     write response channel (always OKAY)
//   pwm_out                                registered PWM output
//   period_tick                            one-cycle pulse at each enabled period wrap
module axil_pwm_slave
  import axil_pwm_slave_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PRE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  axil_awaddr,
  input  logic        axil_awvalid,
  output logic        axil_awready,
  input  logic [31:0] axil_wdata,
  input  logic        axil_wvalid,
  output logic        axil_wready,
  output logic        axil_bvalid,
  input  logic        axil_bready,
  output logic        pwm_out,
  output logic        period_tick
);

  logic             r_aw_held;
  logic             r_w_held;
  logic             r_bvalid;
  logic [3:0]       r_awaddr;
  logic [31:0]      r_wdata;
  logic [1:0]       r_ctrl;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_duty;
  logic [PRE_W-1:0] r_prescale;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_commit;
  logic [3:0]       w_addr;
  logic [3:0]       w_reg_off;
  logic [31:0]      w_data;
  logic             w_unused;

  assign axil_awready = !r_aw_held && !r_bvalid;
  assign axil_wready  = !r_w_held && !r_bvalid;
  assign axil_bvalid  = r_bvalid;

  always_comb begin
    w_aw_hs   = axil_awvalid && axil_awready;
    w_w_hs    = axil_wvalid && axil_wready;
    // Use the held beat if present, otherwise the one handshaking this cycle
    w_addr    = r_aw_held ? r_awaddr : axil_awaddr;
    w_data    = r_w_held ? r_wdata : axil_wdata;
    w_reg_off = {w_addr[3:2], 2'b00};
    w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  end

  // Byte-lane address bits and data above each register's width are dropped on purpose
  assign w_unused = ^{w_data, w_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
    end else begin
      if (w_aw_hs) r_awaddr <= axil_awaddr;
      if (w_w_hs)  r_wdata  <= axil_wdata;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
      end else begin
        if (w_aw_hs) r_aw_held <= 1'b1;
        if (w_w_hs)  r_w_held  <= 1'b1;
        if (r_bvalid && axil_bready) r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_period   <= '0;
      r_duty     <= '0;
      r_prescale <= '0;
    end else if (w_commit) begin
      unique case (w_reg_off)
        AddrCtrl:     r_ctrl     <= {w_data[CtrlPolIdx], w_data[CtrlEnIdx]};
        AddrPeriod:   r_period   <= w_data[CNT_W-1:0];
        AddrDuty:     r_duty     <= w_data[CNT_W-1:0];
        AddrPrescale: r_prescale <= w_data[PRE_W-1:0];
        default: ;
      endcase
    end
  end

  axil_pwm_slave_pwm_core #(
    .CNT_W(CNT_W),
    .PRE_W(PRE_W)
  ) u_pwm_core (
    .clk          (clk),
    .rst          (rst),
    .i_en         (r_ctrl[0]),
    .i_pol        (r_ctrl[1]),
    .i_period     (r_period),
    .i_duty       (r_duty),
    .i_prescale   (r_prescale),
    .o_pwm        (pwm_out),
    .o_period_tick(period_tick)
  );

endmodule
